// File: rtl/bpsk_frame_sync.sv
// BPSK frame synchronizer: recovers symbol timing from a hard-bit stream, hunts for the
// 16-bit sync word (or its inverse), then emits polarity-corrected payload bytes.
// Optional macro FRAME_SYNC_ERR_TOL_EN: accept sync words within Hamming distance 1.

`ifndef SAMPLES_PER_SYMBOL
`define SAMPLES_PER_SYMBOL 8
`endif

module bpsk_frame_sync #(
  parameter int unsigned SAMPLES_PER_SYMBOL = `SAMPLES_PER_SYMBOL,
  parameter logic [15:0] SYNC_WORD          = 16'hD391,
  parameter int unsigned PAYLOAD_BYTES      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       polarity_inv,
  output logic       locked
);

  localparam int unsigned CNT_W = (SAMPLES_PER_SYMBOL > 2) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(SAMPLES_PER_SYMBOL / 2);
  localparam logic [7:0]       LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic {SEARCH, PAYLOAD} state_e;

  state_e           state_q, state_d;
  logic             bit_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sync_q, sync_d;
  logic [7:0]       byte_sr_q, byte_sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             pol_q, pol_d;
  logic             locked_q, locked_d;

  logic             sym_stb;
  logic [15:0]      sync_shift;
  logic             match_true;
  logic             match_inv;
  logic             pay_bit;
  logic [7:0]       byte_shift;

  // Distance test between a received window and a sync pattern.
  function automatic logic sync_hit(input logic [15:0] v, input logic [15:0] pat);
    logic [15:0] d;
    d = v ^ pat;
`ifdef FRAME_SYNC_ERR_TOL_EN
    return (d & (d - 16'd1)) == 16'd0;
`else
    return d == 16'd0;
`endif
  endfunction

  // Symbol timing: counter restarts on every edge so the mid-symbol strobe tracks drift.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (bit_in != bit_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  assign sym_stb    = (cnt_q == CNT_HALF);
  assign sync_shift = {sync_q[14:0], bit_q};
  assign match_true = sync_hit(sync_shift, SYNC_WORD);
  assign match_inv  = sync_hit(sync_shift, ~SYNC_WORD);
  assign pay_bit    = bit_q ^ pol_q;
  assign byte_shift = {byte_sr_q[6:0], pay_bit};

  always_comb begin
    state_d       = state_q;
    sync_d        = sync_q;
    byte_sr_d     = byte_sr_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    pol_d         = pol_q;
    unique case (state_q)
      SEARCH: begin
        if (sym_stb) begin
          sync_d = sync_shift;
          if (match_true || match_inv) begin
            // True pattern wins if both could hit.
            pol_d         = !match_true;
            state_d       = PAYLOAD;
            frame_start_d = 1'b1;
            bit_cnt_d     = '0;
            byte_cnt_d    = '0;
            byte_sr_d     = '0;
          end
        end
      end
      PAYLOAD: begin
        if (sym_stb) begin
          byte_sr_d = byte_shift;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d    = '0;
            byte_out_d   = byte_shift;
            byte_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            if (byte_cnt_q == LAST_BYTE) begin
              frame_done_d = 1'b1;
              state_d      = SEARCH;
              sync_d       = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == PAYLOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      bit_q         <= 1'b0;
      cnt_q         <= '0;
      sync_q        <= '0;
      byte_sr_q     <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pol_q         <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_in;
      cnt_q         <= cnt_d;
      sync_q        <= sync_d;
      byte_sr_q     <= byte_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      pol_q         <= pol_d;
      locked_q      <= locked_d;
    end
  end

  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign polarity_inv = pol_q;
  assign locked       = locked_q;

endmodule

// File: doc/bpsk_frame_sync.md
BPSK_FRAME_SYNC -- requirements
Module: bpsk_frame_sync

Interface
REQ-001 SHALL have parameter SAMPLES_PER_SYMBOL, default `SAMPLES_PER_SYMBOL (params.vh), clk cycles per symbol; even, at least 4.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hD391, 16-bit frame sync pattern, MSB sent first.
REQ-003 SHALL have parameter PAYLOAD_BYTES, default 4, bytes per frame after sync; range 1..255.
REQ-004 clk  input  1  single clock; every register on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bit_in  input  1  hard bit from bpsk_demodulator_top data_out, one per clk.
REQ-007 byte_out  output  8  payload byte, MSB first, polarity-corrected.
REQ-008 byte_valid  output  1  one-cycle strobe qualifying byte_out.
REQ-009 frame_start  output  1  one-cycle pulse on sync detection.
REQ-010 frame_done  output  1  one-cycle pulse, coincident with byte_valid of last payload byte.
REQ-011 polarity_inv  output  1  1 when inverted sync matched (180 deg carrier ambiguity); held until the next sync match.
REQ-012 locked  output  1  high while in PAYLOAD state.

Function
REQ-013 Input bit_in SHALL be registered into bit_q; a transition is bit_in != bit_q.
REQ-014 Symbol counter SHALL be 0 on a transition, else SHALL increment, wrapping SAMPLES_PER_SYMBOL-1 -> 0.
REQ-015 Symbol strobe SHALL fire when counter == SAMPLES_PER_SYMBOL/2; symbol value is bit_q.
REQ-016 State machine SHALL have two states: SEARCH, PAYLOAD.
REQ-017 In SEARCH, each symbol SHALL shift into a 16-bit sync register (LSB in); match compares the post-shift value.
REQ-018 Match to SYNC_WORD SHALL set polarity_inv=0; match to ~SYNC_WORD SHALL set polarity_inv=1; true match has priority.
REQ-019 On a match, next cycle: frame_start=1, state=PAYLOAD, bit and byte counters=0.
REQ-020 In PAYLOAD, each symbol XOR polarity_inv SHALL shift into the byte register, MSB first.
REQ-021 On the 8th bit, the next cycle SHALL present byte_out with byte_valid=1.
REQ-022 byte_out SHALL hold its last value between strobes.
REQ-023 On byte PAYLOAD_BYTES, frame_done=1 with that byte_valid; state SHALL return to SEARCH and the sync register SHALL be cleared to 0.
REQ-024 Sync detection SHALL be disabled in PAYLOAD; payload bits never trigger frame_start.
REQ-025 Symbol counter SHALL keep re-aligning on transitions in both states.
REQ-026 byte_valid, frame_start and frame_done SHALL never exceed one cycle.

Reset
REQ-027 While rst=1: state=SEARCH, all counters and registers=0, all outputs=0 incl. byte_out and polarity_inv.
REQ-028 Reset mid-frame SHALL abandon the frame with no frame_done and no further byte_valid.
REQ-029 The first symbol strobe after reset SHALL occur no earlier than SAMPLES_PER_SYMBOL/2 cycles after rst deasserts.

Configuration
REQ-030 Macro FRAME_SYNC_ERR_TOL_EN defined: sync match SHALL accept Hamming distance <=1 from SYNC_WORD (or ~SYNC_WORD).
REQ-031 Macro FRAME_SYNC_ERR_TOL_EN undefined: exact match only.
REQ-032 Port list, latency and all other behaviour SHALL be identical with and without FRAME_SYNC_ERR_TOL_EN.

Verification (bench: SAMPLES_PER_SYMBOL=8, defaults otherwise; each bit held 8 clk)
REQ-033 Stimulus: sync D391 then A5,3C,00,FF.
- Required: one frame_start.
- Required: four byte_valid carrying A5,3C,00,FF.
- Required: frame_done with FF; polarity_inv=0; locked drops after FF.
REQ-034 Stimulus: bitwise-inverted stream of REQ-033 -> polarity_inv=1; bytes still A5,3C,00,FF.
REQ-035 Stimulus: sync D390 (1 bit error) then payload.
- With macro: lock and correct bytes.
- Without macro: no frame_start, no byte_valid.
REQ-036 Stimulus: rst pulsed 1 cycle during byte 2.
- Required: all outputs 0 next cycle, no frame_done.
- Required: a following clean frame decodes fully.
REQ-037 Stimulus: REQ-033 stream delayed 3 clk, plus 1-clk edge jitter on alternate symbols -> bytes identical to REQ-033.
REQ-038 Stimulus: two back-to-back frames, second sync immediately after first frame_done -> two frame_start, eight bytes, two frame_done.
